// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel, redirect input and decode valid/ready output.
// master = fetch unit side, slave = memory/decode/branch side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_instr;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, FWFT {pc, instr} FIFO, redirect/flush.
// Optional macro FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int unsigned       PC_STEP  = 4,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]  stat_fetched,
  output logic [31:0]  stat_flushed
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              imem_req_r;
  logic [ADDR_W-1:0] imem_addr_r;

  logic [ADDR_W-1:0] fifo_pc_r    [DEPTH];
  logic [DATA_W-1:0] fifo_instr_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              out_valid_r;

  logic              ack_s;
  logic              pop_s;
  logic              push_s;
  logic              discard_s;
  logic [CNT_W-1:0]  count_next_s;
  logic [ADDR_W-1:0] new_pc_s;
  logic [ADDR_W-1:0] pc_inc_s;

  // Handshake qualifiers and next FIFO occupancy.
  always_comb begin
    ack_s     = imem_req_r & bus.imem_ack;
    pop_s     = out_valid_r & bus.out_ready;
    push_s    = ack_s & (state_r == BUSY) & ~bus.redirect_valid;
    discard_s = ack_s & ((state_r == DROP) | bus.redirect_valid);
    new_pc_s  = bus.redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
    pc_inc_s  = pc_r + ADDR_W'(PC_STEP);
    if (bus.redirect_valid) begin
      count_next_s = {CNT_W{1'b0}};
    end else begin
      count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Request FSM: PC, imem_req and imem_addr are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      imem_req_r  <= 1'b0;
      imem_addr_r <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc_r <= new_pc_s;
      case (state_r)
        IDLE: begin
          state_r     <= BUSY;
          imem_req_r  <= 1'b1;
          imem_addr_r <= new_pc_s;
        end
        BUSY: begin
          if (ack_s) begin
            imem_addr_r <= new_pc_s;
          end else begin
            // Stale request must complete at its original address before the new one goes out.
            state_r <= DROP;
          end
        end
        DROP: begin
          state_r <= DROP;
        end
        default: begin
          state_r    <= IDLE;
          imem_req_r <= 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        IDLE: begin
          if (count_r < CNT_W'(DEPTH)) begin
            state_r     <= BUSY;
            imem_req_r  <= 1'b1;
            imem_addr_r <= pc_r;
          end else begin
            imem_req_r <= 1'b0;
          end
        end
        BUSY: begin
          if (ack_s) begin
            pc_r <= pc_inc_s;
            if (count_next_s < CNT_W'(DEPTH)) begin
              imem_addr_r <= pc_inc_s;
            end else begin
              state_r    <= IDLE;
              imem_req_r <= 1'b0;
            end
          end else begin
            state_r <= BUSY;
          end
        end
        DROP: begin
          if (ack_s) begin
            state_r     <= BUSY;
            imem_addr_r <= pc_r;
          end else begin
            state_r <= DROP;
          end
        end
        default: begin
          state_r    <= IDLE;
          imem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and valid flag; redirect flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (bus.redirect_valid) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r     <= count_next_s;
      out_valid_r <= (count_next_s != {CNT_W{1'b0}});
    end
  end

  // FIFO storage; contents are only observable through out_valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_pc_r[wr_ptr_r]    <= pc_r;
      fifo_instr_r[wr_ptr_r] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = imem_req_r;
  assign bus.imem_addr = imem_addr_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_pc    = out_valid_r ? fifo_pc_r[rd_ptr_r]    : {ADDR_W{1'b0}};
  assign bus.out_instr = out_valid_r ? fifo_instr_r[rd_ptr_r] : {DATA_W{1'b0}};

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_r;
  logic [31:0] stat_flushed_r;

  // Push and flush event counters; a redirect that also discards a response counts twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched_r <= 32'd0;
      stat_flushed_r <= 32'd0;
    end else begin
      stat_fetched_r <= stat_fetched_r + {31'd0, push_s};
      stat_flushed_r <= stat_flushed_r + {31'd0, bus.redirect_valid} + {31'd0, discard_s};
    end
  end

  assign stat_fetched = stat_fetched_r;
  assign stat_flushed = stat_flushed_r;
`endif

endmodule
